md_unit_controller: RTL and testbench

Sequences the multiply/divide unit and owns the architectural HI/LO registers for the 5-stage MIPS pipeline. It decodes MD-class instructions in E stage and launches fixed-latency mult/multu/div/divu operations. It serves mfhi/mflo reads and mthi/mtlo writes. It raises a stall toward the hazard unit whenever a D-stage MD-class instruction would collide with an in-flight operation.

---
 rtl/md_unit_controller.sv | 148 ++++++++++++++
 tb/tb_md_unit_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/md_unit_controller.sv
// Multiply/divide sequencer and HI/LO owner: fixed-latency ops, busy for N cycles after start.
// No handshake: collisions are avoided by raising stall toward the hazard unit.
module md_unit_controller #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_instruction,
  input  logic [31:0] e_instruction,
  input  logic [31:0] e_rs_value,
  input  logic [31:0] e_rt_value,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi_lo_read
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic        pend_we_q, pend_we_d;
  logic        busy_q, busy_d;

  function automatic logic is_md(input logic [31:0] ins);
    return (ins[31:26] == 6'b000000) && ((ins[5:2] == 4'b0110) || (ins[5:2] == 4'b0100));
  endfunction

  logic        e_r;
  logic [5:0]  e_funct;
  logic        e_mul, e_div, e_signed;
  logic        e_mthi, e_mtlo, e_mfhi, e_mflo;

  assign e_r      = (e_instruction[31:26] == 6'b000000);
  assign e_funct  = e_instruction[5:0];
  assign e_mul    = e_r && ((e_funct == F_MULT) || (e_funct == F_MULTU));
  assign e_div    = e_r && ((e_funct == F_DIV) || (e_funct == F_DIVU));
  assign e_signed = ~e_funct[0];
  assign e_mthi   = e_r && (e_funct == F_MTHI);
  assign e_mtlo   = e_r && (e_funct == F_MTLO);
  assign e_mfhi   = e_r && (e_funct == F_MFHI);
  assign e_mflo   = e_r && (e_funct == F_MFLO);

  assign start      = (e_mul | e_div) & (state_q == S_IDLE);
  assign busy       = busy_q;
  assign stall      = is_md(d_instruction) & (start | busy_q);
  assign hi_lo_read = e_mfhi ? hi_q : (e_mflo ? lo_q : 32'd0);

  // Division runs on magnitudes so that truncation toward zero and the
  // dividend-signed remainder fall out directly, including 0x80000000 / -1.
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag, div_den, quo_mag, rem_mag, quo, rem;
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  always_comb begin
    rs_neg  = e_signed & e_rs_value[31];
    rt_neg  = e_signed & e_rt_value[31];
    mul_a   = {{32{rs_neg}}, e_rs_value};
    mul_b   = {{32{rt_neg}}, e_rt_value};
    product = mul_a * mul_b;
    rs_mag  = rs_neg ? -e_rs_value : e_rs_value;
    rt_mag  = rt_neg ? -e_rt_value : e_rt_value;
    div_den = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
    quo_mag = rs_mag / div_den;
    rem_mag = rs_mag % div_den;
    quo     = (rs_neg ^ rt_neg) ? -quo_mag : quo_mag;
    rem     = rs_neg ? -rem_mag : rem_mag;
    res_hi  = e_mul ? product[63:32] : rem;
    res_lo  = e_mul ? product[31:0]  : quo;
    res_we  = e_mul | (e_rt_value != 32'd0);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          pend_we_d = res_we;
          cnt_d     = e_mul ? MULT_CNT : DIV_CNT;
          state_d   = S_BUSY;
        end else begin
          if (e_mthi) hi_d = e_rs_value;
          if (e_mtlo) lo_d = e_rs_value;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_BUSY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_md_unit_controller.sv
// Bench for md_unit_controller: expected mfhi/mflo results are queued when driven
// and popped by a monitor when the read is in E; timing checks are made inline.
module tb_md_unit_controller;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_instruction, e_instruction, e_rs_value, e_rt_value;
  logic        start, busy, stall;
  logic [31:0] hi_lo_read;

  always #5 clk = ~clk;

  md_unit_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset),
    .d_instruction(d_instruction), .e_instruction(e_instruction),
    .e_rs_value(e_rs_value), .e_rt_value(e_rt_value),
    .start(start), .busy(busy), .stall(stall), .hi_lo_read(hi_lo_read)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  function automatic logic [31:0] rtype(input logic [5:0] f);
    return {26'b0, f};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    exp_q.push_back(e);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!reset && e_instruction[31:26] == 6'b0 &&
        (e_instruction[5:0] == F_MFHI || e_instruction[5:0] == F_MFLO)) begin
      if (exp_q.size() == 0) begin
        check("sb_pop_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check(mon_e.tag, hi_lo_read, mon_e.val);
      end
    end
  end

  task automatic set_e(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    e_instruction = ins;
    e_rs_value    = rs;
    e_rt_value    = rt;
  endtask

  task automatic read_hl(input logic is_hi, input string tag, input logic [31:0] exp);
    set_e(rtype(is_hi ? F_MFHI : F_MFLO), 32'd0, 32'd0);
    push(tag, exp);
    sample();
    next_cycle();
  endtask

  task automatic mt(input logic is_hi, input logic [31:0] val);
    set_e(rtype(is_hi ? F_MTHI : F_MTLO), val, 32'd0);
    sample();
    check("mt_busy", 32'(busy), 32'd0);
    next_cycle();
  endtask

  // T0 launch, T1..Tn busy, T(n+1) mflo with busy low, T(n+2) mfhi.
  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] rs,
                        input logic [31:0] rt, input int n, input logic [31:0] d_ins,
                        input logic d_md, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    d_instruction = d_ins;
    set_e(rtype(f), rs, rt);
    sample();
    check({name, "_start"}, 32'(start), 32'd1);
    check({name, "_busy_t0"}, 32'(busy), 32'd0);
    check({name, "_stall_t0"}, 32'(stall), 32'(d_md));
    next_cycle();
    set_e(32'd0, 32'd0, 32'd0);
    for (int i = 1; i <= n; i++) begin
      sample();
      check({name, "_busy_run"}, 32'(busy), 32'd1);
      check({name, "_stall_run"}, 32'(stall), 32'(d_md));
      next_cycle();
    end
    set_e(rtype(F_MFLO), 32'd0, 32'd0);
    push({name, "_lo"}, exp_lo);
    sample();
    check({name, "_busy_done"}, 32'(busy), 32'd0);
    check({name, "_stall_done"}, 32'(stall), 32'd0);
    next_cycle();
    d_instruction = 32'd0;
    read_hl(1'b1, {name, "_hi"}, exp_hi);
  endtask

  initial begin
    reset = 1'b1;
    d_instruction = 32'd0;
    set_e(32'd0, 32'd0, 32'd0);
    next_cycle();
    next_cycle();
    sample();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_read", hi_lo_read, 32'd0);
    next_cycle();
    reset = 1'b0;

    mt(1'b1, 32'h12345678);
    mt(1'b0, 32'h9ABCDEF0);
    read_hl(1'b1, "mthi_rd", 32'h12345678);
    read_hl(1'b0, "mtlo_rd", 32'h9ABCDEF0);

    run_op("mult", F_MULT, 32'hFFFFFFFE, 32'd3, MULT_N, 32'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    run_op("multu", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MULT_N, rtype(F_MFHI), 1'b1,
           32'hFFFFFFFE, 32'h00000001);

    // Ops arriving while busy must be ignored; reads return the old HI/LO.
    set_e(rtype(F_MULT), 32'd2, 32'd3);
    sample();
    check("def_start", 32'(start), 32'd1);
    next_cycle();
    set_e(rtype(F_MTHI), 32'hDEADBEEF, 32'd0);
    sample();
    check("def_mthi_busy", 32'(busy), 32'd1);
    next_cycle();
    set_e(rtype(F_DIV), 32'd100, 32'd3);
    sample();
    check("def_start_blocked", 32'(start), 32'd0);
    next_cycle();
    read_hl(1'b1, "def_old_hi", 32'hFFFFFFFE);
    read_hl(1'b0, "def_old_lo", 32'h00000001);
    set_e(32'd0, 32'd0, 32'd0);
    sample();
    check("def_busy_t5", 32'(busy), 32'd1);
    next_cycle();
    sample();
    check("def_busy_t6", 32'(busy), 32'd0);
    next_cycle();
    read_hl(1'b0, "def_lo", 32'd6);
    read_hl(1'b1, "def_hi", 32'd0);

    run_op("div", F_DIV, 32'hFFFFFFF9, 32'd2, DIV_N, rtype(F_ADD), 1'b0,
           32'hFFFFFFFF, 32'hFFFFFFFD);
    mt(1'b1, 32'hAAAAAAAA);
    mt(1'b0, 32'h55555555);
    run_op("divu0", F_DIVU, 32'd7, 32'd0, DIV_N, 32'd0, 1'b0, 32'hAAAAAAAA, 32'h55555555);
    run_op("divovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, DIV_N, 32'd0, 1'b0,
           32'h00000000, 32'h80000000);
    run_op("divu", F_DIVU, 32'hFFFFFFF9, 32'd2, DIV_N, 32'd0, 1'b0, 32'h00000001, 32'h7FFFFFFC);

    // Reset in the middle of a multiply discards the pending result.
    set_e(rtype(F_MULT), 32'd5, 32'd7);
    sample();
    check("rmid_start", 32'(start), 32'd1);
    next_cycle();
    set_e(32'd0, 32'd0, 32'd0);
    for (int i = 1; i <= 2; i++) begin
      sample();
      check("rmid_busy", 32'(busy), 32'd1);
      next_cycle();
    end
    reset = 1'b1;
    sample();
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < MULT_N + 2; i++) begin
      sample();
      check("rmid_idle", 32'(busy), 32'd0);
      next_cycle();
    end
    read_hl(1'b1, "rmid_hi", 32'd0);
    read_hl(1'b0, "rmid_lo", 32'd0);

    set_e(32'd0, 32'd0, 32'd0);
    sample();
    check("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
